dpram_rw_be: RTL
================

# dpram_rw_be

Parametrised simple dual-port RAM: one synchronous read port, one synchronous write port, one clock. It adds the following:
- per-lane byte-enable writes
- selectable read latency (1 or 2) with a read-valid strobe
- a defined same-address collision policy
- an optional hardware clear sequence after reset

It is the general on-chip storage primitive beneath FIFOs, line buffers and register files in the design.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8: byte-enable granularity in bits.
- DATA_DEPTH, 256: number of words; need not be a power of two.
- RD_LATENCY, 1: cycles from accepted read to data; legal values 1 or 2.
- COLLISION_MODE, READ_FIRST: READ_FIRST returns old data on a same-address read/write; WRITE_FIRST returns merged new data.
- INIT_CLEAR, 1: when 1, all words are cleared to 0 after reset.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-low reset.
- busy, out, 1: clear sequence in progress; ports ignored while high.
- rd_en, in, 1: read request.
- rd_addr, in, AW = $clog2(DATA_DEPTH): read address.
- rd_data, out, DATA_WIDTH: read data; holds its last value when no read completes.
- rd_valid, out, 1: one-cycle pulse when rd_data updates with a completed read.
- wr_en, in, 1: write request.
- wr_addr, in, AW: write address.
- wr_data, in, DATA_WIDTH: write data.
- wr_be, in, NL = DATA_WIDTH/LANE_WIDTH: lane enables; bit k covers wr_data[k*LANE_WIDTH +: LANE_WIDTH].

## Operation
- Write: on an edge with wr_en=1, busy=0 and wr_addr<DATA_DEPTH, each lane with wr_be[k]=1 is stored and the other lanes are kept.
  - wr_be=0 is a legal no-op.
  - An out-of-range wr_addr is discarded.
- Read: on an edge with rd_en=1 and busy=0, the array is sampled at rd_addr.
  - An out-of-range rd_addr returns 0.
- Read data holds: with rd_en=0, rd_data holds its value indefinitely. Changing rd_addr alone has no effect.
- Collision, when rd_en and wr_en hit the same in-range address on the same edge:
  - READ_FIRST: the read returns the pre-write word.
  - WRITE_FIRST: the read returns the pre-write word with the enabled lanes replaced by wr_data.
  - The write always completes.
- Clear FSM (INIT_CLEAR=1) has states CLEAR and READY.
  - Reset enters CLEAR with the counter at 0.
  - In CLEAR, one word is written to 0 per cycle. After address DATA_DEPTH-1 the FSM moves to READY.
  - busy is high exactly while in CLEAR.
  - rd_en and wr_en are ignored while busy: no write, no rd_valid.
- INIT_CLEAR=0: the FSM stays in READY, busy is constant 0, and contents after reset are undefined.
- Reset mid-operation:
  - Any reset cycle aborts an in-flight read: no rd_valid is produced for it.
  - Reset restarts the clear from address 0.
  - Array contents are not otherwise reset.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=INIT_CLEAR.
- RD_LATENCY=1: a read accepted at edge N gives rd_data and rd_valid=1 after edge N.
- RD_LATENCY=2: a read accepted at edge N gives rd_data and rd_valid=1 after edge N+1.
  - The array sample is taken at edge N, so a write at edge N+1 to the same address does not affect it.
- Throughput is one read and one write per cycle. Back-to-back reads give back-to-back rd_valid.
- A write at edge N is visible to a read accepted at edge N+1. The same-edge case follows the collision rule.
- With INIT_CLEAR=1, the first rising edge with rst=1 starts the clear. The clear takes DATA_DEPTH cycles.
  - busy falls after the DATA_DEPTH-th clear write.
  - The first port access is accepted on the next edge.

## Structure
- Package dpram_pkg holds:
  - the collision_mode_t enum (READ_FIRST, WRITE_FIRST);
  - the lane-count function NL = DATA_WIDTH/LANE_WIDTH;
  - elaboration checks: DATA_WIDTH % LANE_WIDTH == 0 and RD_LATENCY in {1,2}.
- Sub-module dpram_clear_seq holds the clear FSM, its AW-bit counter, busy, and the clear-write address/enable. The top level muxes the clear write in ahead of port writes.
- The top level holds the array, the lane-merge logic, the collision bypass and the latency pipeline (data plus valid).

## Test plan
- Clear: reset with INIT_CLEAR=1 and DATA_DEPTH=256.
  - busy stays high for 256 cycles.
  - Reads of addresses 0, 128 and 255 afterwards return 0 with rd_valid.
- Byte enables: write 0xDEADBEEF with wr_be=4'b1111 to address 5, then 0x11223344 with wr_be=4'b0101. A read returns 0xDE22BE44.
- Collision: addr 7 holds 0xAAAAAAAA. Read and write 0x55555555 (wr_be=4'b0011) to addr 7 on the same edge.
  - READ_FIRST returns 0xAAAAAAAA.
  - WRITE_FIRST returns 0xAAAA5555.
  - A later read returns 0xAAAA5555 in both modes.
- Latency: with RD_LATENCY=2, issue back-to-back reads of addresses 0..3 holding 0xDE, 0xAD, 0xBE, 0xEF.
  - rd_valid is high for 4 consecutive cycles starting 2 edges after the first read.
  - Data arrives in that order.
- Hold and ignore:
  - Read addr 0, then sweep rd_addr across 0..255 with rd_en=0. rd_data stays at the addr-0 value and rd_valid stays 0.
  - Writes and reads issued while busy have no effect.
- Reset mid-clear: assert rst at clear address 100.
  - busy restarts and stays high for a full 256 cycles.
  - A read in flight at reset yields no rd_valid.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM.
//   collision_mode_t : same-address read/write policy
//   clear_state_t    : states of the post-reset clear sequence
//   lane_count()     : number of byte-enable lanes in a word
//   addr_width()     : address width for a given depth (never below 1)
//   params_ok()      : elaboration-time legality check of the parameter set
package dpram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } collision_mode_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clear_state_t;

    function automatic int unsigned lane_count(input int unsigned data_width,
                                               input int unsigned lane_width);
        return data_width / lane_width;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit params_ok(input int unsigned data_width,
                                     input int unsigned lane_width,
                                     input int unsigned rd_latency);
        return (lane_width != 0) && ((data_width % lane_width) == 0) &&
               ((rd_latency == 1) || (rd_latency == 2));
    endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once, one per cycle,
// while holding busy high.
//   clk, rst     : clock, synchronous active-low reset
//   busy         : clear in progress (registered)
//   clr_en_c     : a clear write is due on the coming edge
//   clr_addr     : address of that clear write (registered counter)
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 256,
    parameter bit          INIT_CLEAR = 1'b1,
    parameter int unsigned AW         = addr_width(DATA_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_en_c,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

    clear_state_t state;

    // Clear FSM; counter restarts from 0 on every reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT_CLEAR ? CLEAR : READY;
            busy     <= INIT_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= READY;
                        busy     <= 1'b0;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                default: begin
                    state <= READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en_c = (state == CLEAR);

endmodule

// File: rtl/dpram_rw_be.sv
// Simple dual-port RAM: one synchronous read port, one byte-enabled write
// port, single clock, selectable read latency, defined collision policy and
// optional hardware clear after reset.
//   clk, rst           : clock, synchronous active-low reset
//   busy               : clear in progress, port requests ignored
//   rd_en, rd_addr     : read request / address
//   rd_data, rd_valid  : read data (holds between reads) / completion pulse
//   wr_en, wr_addr     : write request / address
//   wr_data, wr_be     : write data / per-lane enables
module dpram_rw_be
    import dpram_pkg::*;
#(
    parameter int unsigned     DATA_WIDTH     = 32,
    parameter int unsigned     LANE_WIDTH     = 8,
    parameter int unsigned     DATA_DEPTH     = 256,
    parameter int unsigned     RD_LATENCY     = 1,
    parameter collision_mode_t COLLISION_MODE = READ_FIRST,
    parameter bit              INIT_CLEAR     = 1'b1,
    parameter int unsigned     AW             = addr_width(DATA_DEPTH),
    parameter int unsigned     NL             = lane_count(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NL-1:0]         wr_be
);

    if (!params_ok(DATA_WIDTH, LANE_WIDTH, RD_LATENCY)) begin : g_param_check
        $error("dpram_rw_be: DATA_WIDTH must be a multiple of LANE_WIDTH and RD_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic          clr_en_c;
    logic [AW-1:0] clr_addr;

    dpram_clear_seq #(
        .DATA_DEPTH (DATA_DEPTH),
        .INIT_CLEAR (INIT_CLEAR),
        .AW         (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_en_c (clr_en_c),
        .clr_addr (clr_addr)
    );

    logic                  rd_in_range_c;
    logic                  wr_in_range_c;
    logic                  rd_fire_c;
    logic                  wr_fire_c;
    logic                  collide_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] rd_sample_c;

    // Port qualification, array sample and write-first bypass merge.
    always_comb begin
        rd_in_range_c = (32'(rd_addr) < DATA_DEPTH);
        wr_in_range_c = (32'(wr_addr) < DATA_DEPTH);
        rd_fire_c     = rst && rd_en && !busy;
        wr_fire_c     = rst && wr_en && !busy && wr_in_range_c;
        collide_c     = rd_fire_c && wr_fire_c && (rd_addr == wr_addr);
        rd_word_c     = rd_in_range_c ? mem[rd_addr] : '0;
        rd_sample_c   = rd_word_c;
        if ((COLLISION_MODE == WRITE_FIRST) && collide_c) begin
            for (int k = 0; k < int'(NL); k++) begin
                if (wr_be[k]) begin
                    rd_sample_c[k*LANE_WIDTH +: LANE_WIDTH] = wr_data[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Array write: clear writes take priority, port writes merge per lane.
    always_ff @(posedge clk) begin
        if (rst && clr_en_c) begin
            mem[clr_addr] <= '0;
        end else if (wr_fire_c) begin
            for (int k = 0; k < int'(NL); k++) begin
                if (wr_be[k]) begin
                    mem[wr_addr][k*LANE_WIDTH +: LANE_WIDTH] <= wr_data[k*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    // Read pipeline; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_fire_c;
            if (rd_fire_c) begin
                s1_data <= rd_sample_c;
            end
            if (RD_LATENCY == 1) begin
                rd_valid <= rd_fire_c;
                if (rd_fire_c) begin
                    rd_data <= rd_sample_c;
                end
            end else begin
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    rd_data <= s1_data;
                end
            end
        end
    end

endmodule
